// File: rtl/wave_pkg.sv
// Shared types, sizes and helpers for the waveform capture path.
// Optional feature macro used by this slice: WAVE_CAPTURE_AUTOTRIG_EN.
package wave_pkg;

  localparam int WAVE_SAMPLES     = 256;
  localparam int WAVE_ADDR_WIDTH  = 9;
  localparam int WAVE_VALUE_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_WAIT   = 2'd2
  } wave_state_t;

  // Signed 16-bit sample -> 8-bit offset-binary display value (top byte, sign flipped).
  function automatic logic [WAVE_VALUE_WIDTH-1:0] to_offset_binary(input logic [15:0] sample);
    return {~sample[15], sample[14:8]};
  endfunction

endpackage

// File: rtl/wave_trigger_detect.sv
// Positive-going zero-crossing detector for the capture controller.
// With WAVE_CAPTURE_AUTOTRIG_EN defined, an ARMED period that sees no
// crossing is ended by a forced trigger after AUTOTRIG_SAMPLES misses.
module wave_trigger_detect
  import wave_pkg::*;
#(
  parameter int AUTOTRIG_SAMPLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic new_sample_ready,
  input  logic sample_sign,
  input  logic armed,
  output logic trigger
);

  logic prev_neg;
  logic crossing;

  // Sign of the most recent sample, tracked on every strobe regardless of state.
  always_ff @(posedge clk) begin
    if (reset)                 prev_neg <= 1'b0;
    else if (new_sample_ready) prev_neg <= sample_sign;
  end

  assign crossing = prev_neg & ~sample_sign;

`ifdef WAVE_CAPTURE_AUTOTRIG_EN
  localparam int CNT_W = $clog2(AUTOTRIG_SAMPLES + 1);

  logic [CNT_W-1:0] auto_count;
  logic             auto_fire;

  // Once AUTOTRIG_SAMPLES strobes have missed, the following strobe fires.
  assign auto_fire = (auto_count == CNT_W'(AUTOTRIG_SAMPLES));
  assign trigger   = armed & new_sample_ready & (crossing | auto_fire);

  // Count non-triggering ARMED strobes; cleared whenever the FSM is not ARMED.
  always_ff @(posedge clk) begin
    if (reset || !armed || trigger) auto_count <= '0;
    else if (new_sample_ready)      auto_count <= auto_count + 1'b1;
  end
`else
  assign trigger = armed & new_sample_ready & crossing;
`endif

endmodule

// File: rtl/wave_capture_ctrl.sv
// Write-side controller for the double-buffered 512x8 waveform RAM.
// Captures 256 samples after a trigger into the half not being displayed,
// then flips read_index during display blanking.
// Optional feature macro: WAVE_CAPTURE_AUTOTRIG_EN (forced trigger after
// AUTOTRIG_SAMPLES strobes without a crossing).
//
// state     | meaning
// ST_ARMED  | waiting for a positive-going zero crossing
// ST_ACTIVE | writing samples 1..255 of the trace
// ST_WAIT   | trace complete, waiting for blanking to flip halves
module wave_capture_ctrl
  import wave_pkg::*;
#(
  parameter int AUTOTRIG_SAMPLES = 1024
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        new_sample_ready,
  input  logic [15:0]                 new_sample_in,
  input  logic                        wave_display_idle,
  output logic                        write_enable,
  output logic [WAVE_ADDR_WIDTH-1:0]  write_address,
  output logic [WAVE_VALUE_WIDTH-1:0] write_sample,
  output logic                        read_index
);

  localparam logic [7:0] LAST_INDEX = 8'(WAVE_SAMPLES - 1);

  wave_state_t state, state_next;
  logic [7:0]  index;
  logic [7:0]  write_slot;
  logic        trigger;
  logic        armed;
  logic        capture_write;
  logic        last_write;
  logic        flip;

  wave_trigger_detect #(
    .AUTOTRIG_SAMPLES (AUTOTRIG_SAMPLES)
  ) u_trigger (
    .clk              (clk),
    .reset            (reset),
    .new_sample_ready (new_sample_ready),
    .sample_sign      (new_sample_in[15]),
    .armed            (armed),
    .trigger          (trigger)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_ARMED;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_ARMED:  if (trigger)    state_next = ST_ACTIVE;
      ST_ACTIVE: if (last_write) state_next = ST_WAIT;
      ST_WAIT:   if (flip)       state_next = ST_ARMED;
      default:                   state_next = ST_ARMED;
    endcase
  end

  // Per-state decodes feeding the datapath registers.
  always_comb begin
    armed         = 1'b0;
    capture_write = 1'b0;
    last_write    = 1'b0;
    flip          = 1'b0;
    write_slot    = index;
    case (state)
      ST_ARMED: begin
        armed         = 1'b1;
        capture_write = trigger;
        write_slot    = 8'd0;
      end
      ST_ACTIVE: begin
        capture_write = new_sample_ready;
        last_write    = new_sample_ready && (index == LAST_INDEX);
      end
      ST_WAIT: begin
        flip = wave_display_idle;
      end
      default: ;
    endcase
  end

  // Trace index: 1 after the trigger write, advances per ACTIVE write, 0 elsewhere.
  always_ff @(posedge clk) begin
    if (reset)                     index <= 8'd0;
    else if (armed && trigger)     index <= 8'd1;
    else if (state == ST_ACTIVE) begin
      if (new_sample_ready)        index <= index + 8'd1;
    end
    else                           index <= 8'd0;
  end

  // Display half select, flipped only on WAIT exit.
  always_ff @(posedge clk) begin
    if (reset)     read_index <= 1'b0;
    else if (flip) read_index <= ~read_index;
  end

  // Registered RAM write port; address and data hold between writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_enable  <= 1'b0;
      write_address <= '0;
      write_sample  <= '0;
    end else begin
      write_enable <= capture_write;
      if (capture_write) begin
        write_address <= {~read_index, write_slot};
        write_sample  <= to_offset_binary(new_sample_in);
      end
    end
  end

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Scoreboard bench for wave_capture_ctrl: stimulus pushes expected writes,
// a negedge monitor pops and compares every observed RAM write.
module tb_wave_capture_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic        write_enable;
  logic [8:0]  write_address;
  logic [7:0]  write_sample;
  logic        read_index;

  wave_capture_ctrl #(.AUTOTRIG_SAMPLES(1024)) dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_enable      (write_enable),
    .write_address     (write_address),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] a;
    logic [7:0] d;
    int         c;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks      = 0;
  int   failures    = 0;
  int   cyc         = 0;
  int   writes_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every observed write must match the head of the queue, including its cycle.
  always @(negedge clk) begin
    if (write_enable === 1'b1) begin
      writes_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%h data=%h cycle=%0d (no write expected)",
                 write_address, write_sample, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        if (write_address !== mon_e.a || write_sample !== mon_e.d || cyc != mon_e.c) begin
          failures++;
          $display("FAIL write got addr=%h data=%h cycle=%0d expected addr=%h data=%h cycle=%0d",
                   write_address, write_sample, cyc, mon_e.a, mon_e.d, mon_e.c);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, want);
    end
  endtask

  // All tasks are entered and left 1 time unit after a rising edge.
  task automatic strobe(input logic [15:0] s);
    new_sample_ready = 1'b1;
    new_sample_in    = s;
    @(posedge clk);
    #1;
    new_sample_ready = 1'b0;
  endtask

  task automatic strobe_w(input logic [15:0] s, input logic [8:0] a, input logic [7:0] d);
    exp_t e;
    e.a = a;
    e.d = d;
    e.c = cyc + 1;
    exp_q.push_back(e);
    strobe(s);
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int w0;
    int exp_auto;
    reset             = 1'b1;
    new_sample_ready  = 1'b0;
    new_sample_in     = 16'h0000;
    wave_display_idle = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_we",   32'(write_enable),  32'h0);
    check("reset_addr", 32'(write_address), 32'h0);
    check("reset_data", 32'(write_sample),  32'h0);
    check("reset_ridx", 32'(read_index),    32'h0);

    // Capture 1 into the upper half, mixed gaps and back-to-back strobes.
    strobe(16'hFFFB);
    strobe_w(16'h0300, 9'h100, 8'h83);
    for (int k = 1; k < 256; k++) begin
      strobe_w({1'b0, 7'(k), 8'h00}, 9'(9'h100 + k), {1'b1, 7'(k)});
      if (k < 100) idle_cyc(1);
    end
    idle_cyc(3);
    check("wait_ridx", 32'(read_index), 32'h0);

    // In WAIT a crossing is ignored and no flip happens without idle.
    strobe(16'hFFFF);
    strobe(16'h0001);
    idle_cyc(2);
    check("wait_noflip", 32'(read_index), 32'h0);

    // One-cycle idle pulse flips the half.
    wave_display_idle = 1'b1;
    @(posedge clk);
    #1;
    wave_display_idle = 1'b0;
    check("flip1", 32'(read_index), 32'h1);
    idle_cyc(2);
    check("flip1_hold", 32'(read_index), 32'h1);

    // Capture 2 into the lower half, all back-to-back; last strobe coincides with idle.
    strobe(16'hFF9C);
    strobe_w(16'h7FFF, 9'h000, 8'hFF);
    for (int k = 1; k < 255; k++)
      strobe_w({1'b0, 7'(k), 8'h55}, 9'(k), {1'b1, 7'(k)});
    wave_display_idle = 1'b1;
    strobe_w(16'h2A00, 9'h0FF, 8'hAA);
    check("simul_noflip", 32'(read_index), 32'h1);
    @(posedge clk);
    #1;
    check("simul_flip_next", 32'(read_index), 32'h0);
    wave_display_idle = 1'b0;

    // Capture 3: reset after 100 samples.
    strobe(16'hFFFF);
    strobe_w(16'h0100, 9'h100, 8'h81);
    for (int k = 1; k < 100; k++)
      strobe_w({1'b0, 7'(k), 8'h00}, 9'(9'h100 + k), {1'b1, 7'(k)});
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("midreset_we",   32'(write_enable),  32'h0);
    check("midreset_ridx", 32'(read_index),    32'h0);
    check("midreset_addr", 32'(write_address), 32'h0);

    // After reset prev_neg is clear: positive samples must not write.
    w0 = writes_seen;
    for (int k = 0; k < 20; k++) begin
      strobe(16'h0500);
      if (k[0]) idle_cyc(1);
    end
    check("post_reset_nowrite", 32'(writes_seen - w0), 32'h0);

    // Crossing to exactly zero triggers; capture resumes at index 0 then 1.
    strobe(16'h8000);
    strobe_w(16'h0000, 9'h100, 8'h80);
    strobe_w(16'h0400, 9'h101, 8'h84);
    idle_cyc(2);

    // Only non-negative samples after reset.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    w0 = writes_seen;
`ifdef WAVE_CAPTURE_AUTOTRIG_EN
    exp_auto = 256;
`else
    exp_auto = 0;
`endif
    for (int k = 1; k <= 2000; k++) begin
      if (exp_auto != 0 && k >= 1025 && k < 1281)
        strobe_w(16'h1000, 9'(9'h100 + (k - 1025)), 8'h90);
      else
        strobe(16'h1000);
    end
    idle_cyc(3);
    check("positive_only_writes", 32'(writes_seen - w0), 32'(exp_auto));
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
